// File: rtl/axi_ad9364_chk_pkg.sv
// Shared types and default loopback pattern constants for the AD9364 RX pattern checker
// and the matching transmit generator.
package axi_ad9364_chk_pkg;

   typedef enum logic [1:0] {
      ST_SEARCH = 2'b00,
      ST_TRACK  = 2'b01,
      ST_LOCKED = 2'b10
   } chk_state_e;

   typedef enum logic [1:0] {
      PAT_P1  = 2'd0,
      PAT_P2  = 2'd1,
      PAT_BAD = 2'd2
   } pat_e;

   localparam logic [11:0] AD9364_PAT_IDATA1 = 12'o2064;
   localparam logic [11:0] AD9364_PAT_IDATA2 = 12'o4402;
   localparam logic [11:0] AD9364_PAT_QDATA1 = 12'o1753;
   localparam logic [11:0] AD9364_PAT_QDATA2 = 12'o1337;

   // In two-channel mode channel 2 must carry the same set as channel 1.
   function automatic pat_e pat_classify(
      input logic [11:0] i1,
      input logic [11:0] q1,
      input logic [11:0] i2,
      input logic [11:0] q2,
      input logic        r1_mode,
      input logic [11:0] id1,
      input logic [11:0] id2,
      input logic [11:0] qd1,
      input logic [11:0] qd2
   );
      pat_e c;
      c = PAT_BAD;
      if (i1 == id1 && q1 == qd1) begin
         c = PAT_P1;
      end else if (i1 == id2 && q1 == qd2) begin
         c = PAT_P2;
      end
      if (!r1_mode) begin
         if (c == PAT_P1 && !(i2 == id1 && q2 == qd1)) c = PAT_BAD;
         if (c == PAT_P2 && !(i2 == id2 && q2 == qd2)) c = PAT_BAD;
      end
      return c;
   endfunction

endpackage

// File: rtl/axi_ad9364_sat_cnt.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module axi_ad9364_sat_cnt #(
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 inc_i,
   input  logic                 clr_i,
   output logic [CNT_WIDTH-1:0] cnt_o
);

   logic [CNT_WIDTH-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (inc_i && cnt_q != '1) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/axi_ad9364_rx_pattern_chk.sv
// AD9364 loopback RX checker: locks onto the alternating P1/P2 I/Q pattern and counts errors.
// Optional debug capture of the latest locked-state error: define AD9364_CHK_DBG_EN.
module axi_ad9364_rx_pattern_chk
   import axi_ad9364_chk_pkg::*;
#(
   parameter logic [11:0] IDATA1     = AD9364_PAT_IDATA1,
   parameter logic [11:0] IDATA2     = AD9364_PAT_IDATA2,
   parameter logic [11:0] QDATA1     = AD9364_PAT_QDATA1,
   parameter logic [11:0] QDATA2     = AD9364_PAT_QDATA2,
   parameter int unsigned LOCK_CNT   = 8,
   parameter int unsigned UNLOCK_ERR = 4,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 adc_valid,
   input  logic [11:0]          adc_data_i1,
   input  logic [11:0]          adc_data_q1,
   input  logic [11:0]          adc_data_i2,
   input  logic [11:0]          adc_data_q2,
   input  logic                 adc_r1_mode,
   input  logic                 chk_clr,
   output logic                 chk_locked,
   output logic [1:0]           chk_state,
   output logic [CNT_WIDTH-1:0] chk_err_cnt,
   output logic [CNT_WIDTH-1:0] chk_smp_cnt
`ifdef AD9364_CHK_DBG_EN
   ,
   output logic                 chk_dbg_trigger,
   output logic [49:0]          chk_dbg_data
`endif
);

   localparam logic [7:0] LOCK_C   = 8'(LOCK_CNT);
   localparam logic [7:0] UNLOCK_C = 8'(UNLOCK_ERR);

   chk_state_e state_q, state_d;
   logic [7:0] run_q, run_d;
   logic [7:0] bad_run_q, bad_run_d;
   logic       exp_q, exp_d;          // 0 = expect P1, 1 = expect P2
   logic       r1_mode_q;
   logic       locked_q;
   logic       mode_chg;
   logic       err_inc, smp_inc;
   pat_e       cls, exp_pat;

   assign mode_chg = adc_r1_mode ^ r1_mode_q;
   assign exp_pat  = exp_q ? PAT_P2 : PAT_P1;
   assign cls      = pat_classify(adc_data_i1, adc_data_q1, adc_data_i2, adc_data_q2,
                                  adc_r1_mode, IDATA1, IDATA2, QDATA1, QDATA2);

   always_comb begin
      state_d   = state_q;
      run_d     = run_q;
      bad_run_d = bad_run_q;
      exp_d     = exp_q;
      err_inc   = 1'b0;
      smp_inc   = 1'b0;
      if (mode_chg) begin
         state_d   = ST_SEARCH;
         run_d     = '0;
         bad_run_d = '0;
         exp_d     = 1'b0;
      end else if (adc_valid) begin
         case (state_q)
            ST_SEARCH: begin
               if (cls != PAT_BAD) begin
                  exp_d   = (cls == PAT_P1);
                  run_d   = 8'd1;
                  state_d = ST_TRACK;
               end
            end
            ST_TRACK: begin
               if (cls == exp_pat) begin
                  exp_d = ~exp_q;
                  run_d = run_q + 8'd1;
                  if (run_q + 8'd1 == LOCK_C) begin
                     state_d = ST_LOCKED;
                     run_d   = '0;
                  end
               end else begin
                  state_d = ST_SEARCH;
                  run_d   = '0;
               end
            end
            ST_LOCKED: begin
               exp_d   = ~exp_q;
               smp_inc = 1'b1;
               if (cls == exp_pat) begin
                  bad_run_d = '0;
               end else begin
                  err_inc = 1'b1;
                  if (bad_run_q + 8'd1 == UNLOCK_C) begin
                     state_d   = ST_SEARCH;
                     bad_run_d = '0;
                  end else begin
                     bad_run_d = bad_run_q + 8'd1;
                  end
               end
            end
            default: begin
               state_d   = ST_SEARCH;
               run_d     = '0;
               bad_run_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_SEARCH;
         run_q     <= '0;
         bad_run_q <= '0;
         exp_q     <= 1'b0;
         r1_mode_q <= 1'b0;
         locked_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         run_q     <= run_d;
         bad_run_q <= bad_run_d;
         exp_q     <= exp_d;
         r1_mode_q <= adc_r1_mode;
         locked_q  <= (state_d == ST_LOCKED);
      end
   end

   assign chk_locked = locked_q;
   assign chk_state  = state_q;

   axi_ad9364_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_err_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (err_inc),
      .clr_i (chk_clr),
      .cnt_o (chk_err_cnt)
   );

   axi_ad9364_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_smp_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (smp_inc),
      .clr_i (chk_clr),
      .cnt_o (chk_smp_cnt)
   );

`ifdef AD9364_CHK_DBG_EN
   logic        dbg_trig_q;
   logic [49:0] dbg_data_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dbg_trig_q <= 1'b0;
         dbg_data_q <= '0;
      end else begin
         dbg_trig_q <= err_inc;
         if (err_inc) begin
            dbg_data_q <= {exp_q, adc_data_i1, adc_data_q1, adc_data_i2, adc_data_q2,
                           bad_run_q[0]};
         end
      end
   end

   assign chk_dbg_trigger = dbg_trig_q;
   assign chk_dbg_data    = dbg_data_q;
`endif

endmodule

// File: tb/tb_axi_ad9364_rx_pattern_chk.sv
// Directed self-checking bench for axi_ad9364_rx_pattern_chk (default and saturation configs).
module tb_axi_ad9364_rx_pattern_chk;

   localparam logic [11:0] I1 = 12'o2064;
   localparam logic [11:0] I2 = 12'o4402;
   localparam logic [11:0] Q1 = 12'o1753;
   localparam logic [11:0] Q2 = 12'o1337;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        adc_valid = 1'b0;
   logic [11:0] di1 = '0, dq1 = '0, di2 = '0, dq2 = '0;
   logic        r1_mode = 1'b1;
   logic        clr = 1'b0;

   logic        locked, locked2;
   logic [1:0]  state, state2;
   logic [15:0] err, smp;
   logic [7:0]  err2, smp2;

   int unsigned n_chk = 0;
   int unsigned n_err = 0;
   bit          nxt_p2 = 1'b0;

   always #5 clk = ~clk;

   axi_ad9364_rx_pattern_chk dut (
      .clk         (clk),
      .rst         (rst),
      .adc_valid   (adc_valid),
      .adc_data_i1 (di1),
      .adc_data_q1 (dq1),
      .adc_data_i2 (di2),
      .adc_data_q2 (dq2),
      .adc_r1_mode (r1_mode),
      .chk_clr     (clr),
      .chk_locked  (locked),
      .chk_state   (state),
      .chk_err_cnt (err),
      .chk_smp_cnt (smp)
`ifdef AD9364_CHK_DBG_EN
      ,
      .chk_dbg_trigger (),
      .chk_dbg_data    ()
`endif
   );

   axi_ad9364_rx_pattern_chk #(
      .UNLOCK_ERR (255),
      .CNT_WIDTH  (8)
   ) dut_sat (
      .clk         (clk),
      .rst         (rst),
      .adc_valid   (adc_valid),
      .adc_data_i1 (di1),
      .adc_data_q1 (dq1),
      .adc_data_i2 (di2),
      .adc_data_q2 (dq2),
      .adc_r1_mode (r1_mode),
      .chk_clr     (clr),
      .chk_locked  (locked2),
      .chk_state   (state2),
      .chk_err_cnt (err2),
      .chk_smp_cnt (smp2)
`ifdef AD9364_CHK_DBG_EN
      ,
      .chk_dbg_trigger (),
      .chk_dbg_data    ()
`endif
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic drive(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c,
                        input logic [11:0] d, input logic v, input logic cl);
      @(negedge clk);
      di1 = a; dq1 = b; di2 = c; dq2 = d;
      adc_valid = v;
      clr = cl;
      @(posedge clk);
      #1;
      adc_valid = 1'b0;
      clr = 1'b0;
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned k = 0; k < n; k++) drive('0, '0, '0, '0, 1'b0, 1'b0);
   endtask

   // Next alternation sample, good or with i1 corrupted; ch2 may be corrupted separately.
   task automatic lk(input bit good, input bit cl = 1'b0, input bit ch2_bad = 1'b0);
      logic [11:0] a, b;
      a = nxt_p2 ? I2 : I1;
      b = nxt_p2 ? Q2 : Q1;
      drive(good ? a : 12'o0000, b, ch2_bad ? 12'o7777 : a, b, 1'b1, cl);
      nxt_p2 = ~nxt_p2;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      idle(2);
      nxt_p2 = 1'b0;
   endtask

   initial begin
      int unsigned seen_lock;

      // Reset values
      idle(2);
      check("rst_locked", locked, 0);
      check("rst_state", state, 0);
      check("rst_err", err, 0);
      check("rst_smp", smp, 0);
      @(negedge clk);
      rst = 1'b0;
      idle(2);

      // Clean lock, single channel
      for (int unsigned k = 0; k < 8; k++) begin
         lk(1'b1);
         if (k == 0) check("lock_st_track", state, 1);
         if (k == 6) check("lock_not_yet", locked, 0);
      end
      check("lock_locked", locked, 1);
      check("lock_state", state, 2);
      check("lock_err", err, 0);
      check("lock_smp", smp, 0);

      // Single corrupted sample
      lk(1'b0);
      for (int unsigned k = 0; k < 3; k++) lk(1'b1);
      check("onebad_err", err, 1);
      check("onebad_smp", smp, 4);
      check("onebad_locked", locked, 1);

      // Clear alone, then 4 consecutive errors drop lock
      drive('0, '0, '0, '0, 1'b0, 1'b1);
      check("clr_err", err, 0);
      check("clr_smp", smp, 0);
      check("clr_state", state, 2);
      for (int unsigned k = 0; k < 3; k++) lk(1'b0);
      check("bad3_locked", locked, 1);
      check("bad3_err", err, 3);
      lk(1'b0);
      check("bad4_err", err, 4);
      check("bad4_smp", smp, 4);
      check("bad4_locked", locked, 0);
      check("bad4_state", state, 0);
      for (int unsigned k = 0; k < 8; k++) begin
         lk(1'b1);
         if (k == 6) check("relock_not_yet", locked, 0);
      end
      check("relock", locked, 1);
      check("relock_err", err, 4);

      // Asynchronous reset mid-operation
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_locked", locked, 0);
      check("arst_state", state, 0);
      check("arst_err", err, 0);
      @(negedge clk);
      rst = 1'b0;
      idle(2);

      // P1 only never locks
      seen_lock = 0;
      for (int unsigned k = 0; k < 20; k++) begin
         drive(I1, Q1, I1, Q1, 1'b1, 1'b0);
         if (locked) seen_lock++;
      end
      check("p1only_lock_seen", seen_lock, 0);
      check("p1only_state", state, 0);

      // Two-channel mode: bad ch2 never locks, good ch2 locks
      @(negedge clk);
      r1_mode = 1'b0;
      idle(2);
      nxt_p2 = 1'b0;
      seen_lock = 0;
      for (int unsigned k = 0; k < 12; k++) begin
         lk(1'b1, 1'b0, 1'b1);
         if (locked) seen_lock++;
      end
      check("ch2bad_lock_seen", seen_lock, 0);
      check("ch2bad_state", state, 0);
      for (int unsigned k = 0; k < 8; k++) lk(1'b1);
      check("ch2ok_locked", locked, 1);
      @(negedge clk);
      r1_mode = 1'b1;
      @(posedge clk);
      #1;
      check("modechg_state", state, 0);
      check("modechg_locked", locked, 0);

      // Clear coinciding with an error
      idle(1);
      for (int unsigned k = 0; k < 8; k++) lk(1'b1);
      check("lock2", locked, 1);
      for (int unsigned k = 0; k < 4; k++) begin
         lk(1'b0);
         lk(1'b1);
      end
      lk(1'b0);
      check("pre_clr_err", err, 5);
      check("pre_clr_smp", smp, 9);
      lk(1'b0, 1'b1);
      check("clr_hit_err", err, 0);
      check("clr_hit_smp", smp, 0);
      check("clr_hit_locked", locked, 1);
      lk(1'b0);
      check("post_clr_err", err, 1);
      check("post_clr_locked", locked, 1);

      // Counter saturation on the 8-bit, UNLOCK_ERR=255 instance
      do_reset();
      for (int unsigned k = 0; k < 8; k++) lk(1'b1);
      check("sat_lock", locked2, 1);
      for (int unsigned k = 0; k < 300; k++) begin
         lk(1'b0);
         lk(1'b1);
      end
      check("sat_err", err2, 8'hFF);
      check("sat_smp", smp2, 8'hFF);
      check("sat_locked", locked2, 1);
      check("wide_err", err, 300);
      check("wide_smp", smp, 600);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
